// File: rtl/mux_arbiter.sv
// mux_arbiter: round-robin owner of the shared 4:1 result mux.
// Four requesters compete for the mux. The winner's index drives `control`, and its
// operand is captured into `result`. That register is offered downstream with a
// valid/ready handshake.
// Optional feature macro: MUX_ARB_LOCK_EN. When it is defined, a `lock` port lets the
// current owner keep the mux for at most four consecutive transfers.
module mux_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       req,
  input  logic [WIDTH-1:0] zero_zero,
  input  logic [WIDTH-1:0] zero_one,
  input  logic [WIDTH-1:0] one_zero,
  input  logic [WIDTH-1:0] one_one,
`ifdef MUX_ARB_LOCK_EN
  input  logic [3:0]       lock,
`endif
  input  logic             out_ready,
  output logic [1:0]       control,
  output logic [3:0]       grant,
  output logic             out_valid,
  output logic [WIDTH-1:0] result
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       control_q, control_d;
  logic [1:0]       lastPtr_q, lastPtr_d;
  logic [WIDTH-1:0] result_q, result_d;
`ifdef MUX_ARB_LOCK_EN
  logic [1:0]       lockCnt_q, lockCnt_d;
`endif

  logic [WIDTH-1:0] operand [4];
  logic [3:0]       eligible;
  logic [1:0]       prioBase;
  logic             lockHold;
  logic             found;
  logic [1:0]       pick;

  assign operand[0] = zero_zero;
  assign operand[1] = zero_one;
  assign operand[2] = one_zero;
  assign operand[3] = one_one;

  // Who may compete this edge: on an accept the owner is masked and becomes the new priority base.
  always_comb begin
    eligible = req;
    prioBase = lastPtr_q;
    lockHold = 1'b0;
    if (state_q == BUSY && out_ready) begin
      prioBase = control_q;
      eligible = req & ~(4'b0001 << control_q);
`ifdef MUX_ARB_LOCK_EN
      if (lock[control_q] && req[control_q]) begin
        if (lockCnt_q != 2'd3 || eligible == 4'b0000) begin
          lockHold = 1'b1;
        end
      end
`endif
    end
  end

  // Scan last+1 .. last+4 (mod 4) and take the first eligible requester.
  always_comb begin
    found = 1'b0;
    pick  = 2'd0;
    for (int off = 1; off <= 4; off++) begin
      logic [1:0] idx;
      idx = prioBase + 2'(off);
      if (!found && eligible[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  // Next-state logic: grant from IDLE, hold while stalled, and reload or retire on accept.
  always_comb begin
    state_d   = state_q;
    control_d = control_q;
    result_d  = result_q;
    lastPtr_d = lastPtr_q;
`ifdef MUX_ARB_LOCK_EN
    lockCnt_d = lockCnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (found) begin
          state_d   = BUSY;
          control_d = pick;
          result_d  = operand[pick];
`ifdef MUX_ARB_LOCK_EN
          if (pick != control_q) begin
            lockCnt_d = 2'd0;
          end
`endif
        end
      end
      BUSY: begin
        if (out_ready) begin
          if (lockHold) begin
            result_d = operand[control_q];
`ifdef MUX_ARB_LOCK_EN
            if (lockCnt_q != 2'd3) begin
              lockCnt_d = lockCnt_q + 2'd1;
            end
`endif
          end else begin
            lastPtr_d = control_q;
            if (found) begin
              control_d = pick;
              result_d  = operand[pick];
`ifdef MUX_ARB_LOCK_EN
              lockCnt_d = 2'd0;
`endif
            end else begin
              state_d = IDLE;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset gives requester 0 first priority and drops any transfer in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      control_q <= 2'd0;
      lastPtr_q <= 2'd3;
      result_q  <= '0;
`ifdef MUX_ARB_LOCK_EN
      lockCnt_q <= 2'd0;
`endif
    end else begin
      state_q   <= state_d;
      control_q <= control_d;
      lastPtr_q <= lastPtr_d;
      result_q  <= result_d;
`ifdef MUX_ARB_LOCK_EN
      lockCnt_q <= lockCnt_d;
`endif
    end
  end

  assign control   = control_q;
  assign result    = result_q;
  assign out_valid = (state_q == BUSY);
  assign grant     = out_valid ? (4'b0001 << control_q) : 4'b0000;

endmodule

// File: doc/mux_arbiter.md
# mux_arbiter

Round-robin arbiter and sequencer for the shared 4:1 result mux on the datapath. It arbitrates among four requesters, drives the 2-bit `control` select, and captures the selected operand into an output register. It presents that register downstream with a valid/ready handshake. It replaces the free-running select currently wired to the mux, so that ownership of the mux is explicit and one grant is held per transfer.

## Interface

- `WIDTH`, 32, data width of each requester operand and of `result`.
- `clk` input 1: single clock; all state updates on rising edge.
- `reset` input 1: synchronous, active-high.
- `req` input 4: request per requester; bit i corresponds to select value i.
- `zero_zero`, `zero_one`, `one_zero`, `one_one` input WIDTH: operands of requesters 0..3.
- `lock` input 4: per-requester lock request; present only with `MUX_ARB_LOCK_EN`.
- `out_ready` input 1: downstream accepts `result` this cycle.
- `control` output 2: registered index of the currently granted requester.
- `grant` output 4: one-hot; `grant[i] = out_valid && control == i`.
- `out_valid` output 1: `result` holds a granted operand.
- `result` output WIDTH: registered copy of the granted operand.

## Operation

- States:
  - IDLE: `out_valid` = 0.
  - BUSY: `out_valid` = 1, holding a transfer.
- Round-robin pointer `last` (2 bits) holds the index of the last accepted requester. Priority order is `last+1`, `last+2`, `last+3`, `last`, wrapping mod 4.
- IDLE with any eligible `req` bit:
  - Pick the highest-priority eligible requester k.
  - Load `control` = k and `result` = operand k.
  - Go to BUSY.
- IDLE with no eligible request: stay in IDLE; `control` and `result` hold their values.
- BUSY with `out_ready` = 0:
  - Hold `control`, `result` and `grant` stable.
  - Changes on `req` are ignored.
- BUSY with `out_ready` = 1 (transfer accepted):
  - Set `last` = `control`.
  - Arbitrate in the same edge, with the just-accepted requester masked.
  - If another requester is eligible, reload and stay in BUSY (back-to-back transfer, no bubble).
  - Otherwise go to IDLE.
- Eligibility: a requester is eligible when its `req` bit is 1 and it is not masked. The mask applies only on the accept edge.
- Requester protocol:
  - Hold `req[i]` until it observes `grant[i] && out_ready`.
  - Drop `req[i]` the next cycle, or keep it high to queue another transfer. A kept-high request is granted no earlier than one cycle later.
- Operand sampling: the operand is sampled only on the grant edge. Later operand changes do not affect `result`.
- Reset:
  - `out_valid` = 0, `grant` = 0, `control` = 2'b00, `result` = 0, `last` = 3 (requester 0 has first priority).
  - Lock counter = 0.
  - Reset asserted mid-transfer abandons that transfer; it is not replayed.

## Timing

- Grant latency: `req` sampled high at edge N (IDLE) gives `out_valid`, `control` and `result` valid after edge N, i.e. during cycle N+1.
- Throughput: with two or more continuous requesters, one transfer per cycle while `out_ready` = 1.
- Single requester holding `req` high: one transfer every 2 cycles, because of the mask bubble.
- All outputs are registered; there is no combinational path from `req` or operands to outputs. `grant` is decoded from registered state only.
- Simultaneous accept and new requests: the accepted requester loses; the remaining requesters are ordered by the new `last`.

## Configuration

- Macro: `MUX_ARB_LOCK_EN`.
- Defined:
  - Adds the `lock` port and a 2-bit lock counter.
  - On accept, if `lock[control]` and `req[control]` are both 1, the same requester is re-granted without the mask and `last` does not advance.
  - At most 4 consecutive locked grants are allowed. After the 4th, the mask applies and rotation is forced if any other requester is eligible; otherwise the lock continues.
  - The counter clears on any grant to a different requester and on reset.
- Undefined: no `lock` port; behaviour is exactly as described in Operation.

## Test plan

- Reset, then `req` = 4'b0001, operand0 = 32'hDEADBEEF, `out_ready` = 1 → cycle after reset release: `out_valid` = 1, `control` = 0, `grant` = 4'b0001, `result` = 32'hDEADBEEF. Next cycle `out_valid` = 0.
- `req` = 4'b1111 held, `out_ready` = 1 → `control` sequence 0, 1, 2, 3, 0, with `out_valid` high every cycle.
- Granted to requester 2, `out_ready` = 0 for 5 cycles while operand2 and `req` change → `result`, `control` = 2 and `grant` = 4'b0100 stay stable. Accept on cycle 6.
- Only `req[3]` held high → transfers occur on alternate cycles, `control` = 3 each time.
- Assert `reset` while BUSY with `out_ready` = 0 → the next cycle shows all outputs at their reset values; afterwards requester 0 wins over requester 1 when both request.
- With `MUX_ARB_LOCK_EN`: `req` = 4'b0011, `lock[1]` = 1, first grant to 1 → `control` = 1 for 4 consecutive accepts, then 0.
